// File: rtl/tm1638_pkg.sv
// Shared segment encodings for TM1638 digit drivers: bit0=a .. bit6=g, bit7=dp.
package tm1638_pkg;

  typedef logic [7:0] seg_t;

  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F_BIT = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  localparam seg_t SEG_0 = 8'h3F;
  localparam seg_t SEG_1 = 8'h06;
  localparam seg_t SEG_2 = 8'h5B;
  localparam seg_t SEG_3 = 8'h4F;
  localparam seg_t SEG_4 = 8'h66;
  localparam seg_t SEG_5 = 8'h6D;
  localparam seg_t SEG_6 = 8'h7D;
  localparam seg_t SEG_7 = 8'h07;
  localparam seg_t SEG_8 = 8'h7F;
  localparam seg_t SEG_9 = 8'h6F;
  localparam seg_t SEG_A_HEX = 8'h77;
  localparam seg_t SEG_B_HEX = 8'h7C;
  localparam seg_t SEG_C_HEX = 8'h39;
  localparam seg_t SEG_D_HEX = 8'h5E;
  localparam seg_t SEG_E_HEX = 8'h79;
  localparam seg_t SEG_F     = 8'h71;

  localparam seg_t SEG_BLANK = 8'h00;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-high 7-segment byte (dp always 0).
module hex_to_seg7
  import tm1638_pkg::*;
(
  input  logic [3:0] in,
  output seg_t       seg
);

  // Full 16-entry decode; default only exists as a safe fallback.
  always_comb begin
    seg = SEG_BLANK;
    case (in)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A_HEX;
      4'hB:    seg = SEG_B_HEX;
      4'hC:    seg = SEG_C_HEX;
      4'hD:    seg = SEG_D_HEX;
      4'hE:    seg = SEG_E_HEX;
      4'hF:    seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/data_to_tm1638.sv
// One TM1638 digit: hex decode, blanking, optional decimal point and polarity, registered.
// Define DATA_TO_TM1638_DP_EN to add the dp input driving out[7].
module data_to_tm1638
  import tm1638_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       blank,
`ifdef DATA_TO_TM1638_DP_EN
  input  logic       dp,
`endif
  input  logic [3:0] in,
  output logic [7:0] out
);

  localparam seg_t POL_MASK  = {8{ACTIVE_LOW}};
  localparam seg_t RESET_VAL = SEG_BLANK ^ POL_MASK;

  seg_t dec_s;
  seg_t seg_s;
  seg_t out_r;

  hex_to_seg7 u_dec (
    .in  (in),
    .seg (dec_s)
  );

  // Blank/dp muxing and polarity applied ahead of the register.
  always_comb begin
    seg_s = dec_s;
`ifdef DATA_TO_TM1638_DP_EN
    seg_s[SEG_DP] = dp;
`else
    seg_s[SEG_DP] = 1'b0;
`endif
    if (blank) begin
      seg_s = SEG_BLANK;
    end else begin
      seg_s = seg_s;
    end
    seg_s = seg_s ^ POL_MASK;
  end

  // Output register; reset wins so unknown inputs never reach it while rst=1.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r <= RESET_VAL;
    end else begin
      out_r <= seg_s;
    end
  end

  assign out = out_r;

endmodule

// File: tb/tb_data_to_tm1638.sv
// Vector-table bench for data_to_tm1638 (active-high and active-low instances).
module tb_data_to_tm1638;

  typedef struct {
    logic       rst;
    logic       blank;
    logic       dp;
    logic [3:0] in;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    int         idx;
    logic [7:0] exp_hi;
    logic [7:0] exp_lo;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst, blank, dp;
  logic [3:0] in;
  logic [7:0] out_hi, out_lo;

  int checks = 0;
  int failures = 0;

  vec_t vecs[$];
  sb_t  sbq[$];
  logic [7:0] ref_tab [16];

  always #5 clk = ~clk;

  data_to_tm1638 #(.ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .rst(rst), .blank(blank),
`ifdef DATA_TO_TM1638_DP_EN
    .dp(dp),
`endif
    .in(in), .out(out_hi)
  );

  data_to_tm1638 #(.ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .rst(rst), .blank(blank),
`ifdef DATA_TO_TM1638_DP_EN
    .dp(dp),
`endif
    .in(in), .out(out_lo)
  );

  task automatic add(input logic r, input logic b, input logic d,
                     input logic [3:0] i, input logic [7:0] e);
    vec_t v;
    v.rst = r; v.blank = b; v.dp = d; v.in = i; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic step(input int idx, input vec_t v);
    sb_t s, got;
    rst = v.rst; blank = v.blank; dp = v.dp; in = v.in;
    s.idx = idx; s.exp_hi = v.exp; s.exp_lo = ~v.exp;
    sbq.push_back(s);
    @(posedge clk);
    #1;
    got = sbq.pop_front();
    checks++;
    if (out_hi !== got.exp_hi) begin
      failures++;
      $display("FAIL hi_vec%0d: out=%02h expected=%02h", got.idx, out_hi, got.exp_hi);
    end
    checks++;
    if (out_lo !== got.exp_lo) begin
      failures++;
      $display("FAIL lo_vec%0d: out=%02h expected=%02h", got.idx, out_lo, got.exp_lo);
    end
  endtask

  initial begin
    vec_t v;
    logic [7:0] dp_exp;
    ref_tab = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
`ifdef DATA_TO_TM1638_DP_EN
    dp_exp = 8'h86;
`else
    dp_exp = 8'h06;
`endif

    // reset, then first decode one edge after release
    add(1'b1, 1'b0, 1'b0, 4'h9, 8'h00);
    add(1'b1, 1'b0, 1'b0, 4'h9, 8'h00);
    add(1'b0, 1'b0, 1'b0, 4'h9, 8'h6F);
    add(1'b0, 1'b0, 1'b0, 4'h1, 8'h06);
    add(1'b0, 1'b0, 1'b0, 4'h2, 8'h5B);
    add(1'b0, 1'b0, 1'b0, 4'h3, 8'h4F);
    for (int i = 0; i < 16; i++) add(1'b0, 1'b0, 1'b0, 4'(i), ref_tab[i]);
    // blank overrides, release, reset mid-stream, X held off by reset
    add(1'b0, 1'b1, 1'b0, 4'h8, 8'h00);
    add(1'b0, 1'b0, 1'b0, 4'h8, 8'h7F);
    add(1'b1, 1'b0, 1'b0, 4'h8, 8'h00);
    add(1'b1, 1'b0, 1'b0, 4'bxxxx, 8'h00);
    add(1'b1, 1'b1, 1'b1, 4'hF, 8'h00);
    add(1'b0, 1'b0, 1'b0, 4'h0, 8'h3F);
    // decimal point, and dp under blank
    add(1'b0, 1'b0, 1'b1, 4'h1, dp_exp);
    add(1'b0, 1'b1, 1'b1, 4'h1, 8'h00);
    add(1'b0, 1'b0, 1'b0, 4'hA, 8'h77);

    foreach (vecs[k]) step(k, vecs[k]);

    // hand sequence: blank held several cycles then released back-to-back changes
    v.rst = 1'b0; v.dp = 1'b0;
    for (int k = 0; k < 3; k++) begin
      v.blank = 1'b1; v.in = 4'hE; v.exp = 8'h00;
      step(100 + k, v);
    end
    v.blank = 1'b0; v.in = 4'hE; v.exp = 8'h79; step(103, v);
    v.blank = 1'b0; v.in = 4'hD; v.exp = 8'h5E; step(104, v);
    v.blank = 1'b1; v.in = 4'hC; v.exp = 8'h00; step(105, v);
    v.blank = 1'b0; v.in = 4'hC; v.exp = 8'h39; step(106, v);

    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: left=%0d expected=0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
